imem_loader: RTL

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word to a writable instruction memory at byte addresses 0x00, 0x04, 0x08, … (word index = addr[7:2]). Holds the CPU in reset via `cpu_hold` until a load completes. Sits between the host/UART byte source and the instruction memory write port.

---
 rtl/imem_loader.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Receives bytes over a valid/ready handshake and packs them little-endian
// into 32-bit words. Each word is written to the instruction memory at byte
// addresses 0x00, 0x04, 0x08, ... . The CPU is held in reset via cpu_hold
// until a load completes successfully.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one trailing byte must equal the XOR of all data bytes.
//   A mismatch ends in ERROR with err = 1 and cpu_hold = 1.
//   When undefined, the last write goes straight to DONE and err is tied 0.
//
// Parameters
//   DEPTH_WORDS  maximum number of words loadable (word_count = 0 selects it)
//   ADDR_W       width of the byte address mem_addr
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   pulse; begins a load when not busy
//   word_count  in   words to load, latched on start (0 -> DEPTH_WORDS)
//   in_data     in   stream byte
//   in_valid    in   in_data valid
//   in_ready    out  loader accepts a byte this cycle
//   mem_we      out  one-cycle instruction memory write strobe
//   mem_addr    out  word-aligned byte address of the write
//   mem_wdata   out  assembled instruction word
//   busy        out  load in progress
//   done        out  last load completed successfully
//   err         out  checksum mismatch (macro only, else 0)
//   cpu_hold    out  processor reset request

module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam logic [6:0] DEPTH_CNT = 7'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [6:0]  cnt;        // words requested for this load (1..DEPTH_WORDS)
  logic [6:0]  widx;       // index of the next word to be written
  logic [1:0]  lane;       // byte lane for the next accepted byte
  logic [31:0] word;       // word under assembly
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;       // running XOR of all data bytes
`endif

  logic        hs;
  logic        idle_like;
  logic        last_word;
  logic [6:0]  cnt_sel;

  assign hs        = in_valid && in_ready;
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign last_word = (widx + 7'd1) == cnt;

  // Zero selects the full depth; oversized requests are capped so the word
  // index can never wrap past the last address.
  assign cnt_sel = ((word_count == 7'd0) || (word_count > DEPTH_CNT))
                   ? DEPTH_CNT : word_count;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (hs && (lane == 2'd3)) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = RECV;
        end
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (hs) begin
          state_nxt = (in_data == csum) ? DONE : ERROR;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: count latch, word index, byte lane, word assembly, checksum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 7'd0;
      widx <= 7'd0;
      lane <= 2'd0;
      word <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= 8'd0;
`endif
    end else begin
      if (idle_like && start) begin
        cnt  <= cnt_sel;
        widx <= 7'd0;
        lane <= 2'd0;
        word <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= 8'd0;
`endif
      end else if ((state == RECV) && hs) begin
        // Lane wraps 3 -> 0 on the fourth byte, ready for the next word.
        word[{lane, 3'b000} +: 8] <= in_data;
        lane                      <= lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum                      <= csum ^ in_data;
`endif
      end else if (state == WRITE) begin
        widx <= widx + 7'd1;
      end
    end
  end

  // Outputs are decoded from registered state only, so in_ready never
  // depends combinationally on in_valid.
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_hold  = 1'b1;
    case (state)
      RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'({widx, 2'b00});
        mem_wdata = word;
        busy      = 1'b1;
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        busy     = 1'b1;
`endif
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERROR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        err = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

endmodule
